vid_ram_arb: RTL and testbench

VID_RAM_ARB -- requirements
Module: vid_ram_arb

---
 rtl/vid_ram_arb.sv | 120 ++++++++++++
 tb/tb_vid_ram_arb.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vid_ram_arb.sv
// Video RAM arbiter: one pending slot each for CPU and VDG, a registered single-port RAM
// interface, and a two-stage completion pipeline back to the requester that was granted.
module vid_ram_arb #(
  parameter int unsigned ADDR_W       = 13,
  parameter int unsigned CPU_MAX_WAIT = 2
) (
  input  logic              clk25,
  input  logic              hard_reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  input  logic              vdg_req,
  input  logic [ADDR_W-1:0] vdg_addr,
  output logic [7:0]        vdg_rdata,
  output logic              vdg_valid,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              cpu_overrun,
  output logic              vdg_overrun
);

  localparam logic [1:0] MaxWait = 2'(CPU_MAX_WAIT);

  typedef enum logic [1:0] {StIdle, StCpuAcc, StVdgAcc} state_e;

  state_e              state_q;
  logic                cpu_v_q, cpu_we_q, vdg_v_q;
  logic [ADDR_W-1:0]   cpu_addr_q, vdg_addr_q;
  logic [7:0]          cpu_wdata_q;
  logic [1:0]          cpu_wait_q;
  logic                cmp_v_q, cmp_cpu_q, cmp_we_q;
  logic                gnt_cpu, gnt_vdg;

  // VDG wins contention until the CPU has been starved for MaxWait cycles.
  always_comb begin
    gnt_vdg = vdg_v_q && !(cpu_v_q && (cpu_wait_q >= MaxWait));
    gnt_cpu = cpu_v_q && !gnt_vdg;
  end

  always_ff @(posedge clk25 or negedge hard_reset_n) begin
    if (!hard_reset_n) begin
      state_q     <= StIdle;
      cpu_v_q     <= 1'b0;
      cpu_we_q    <= 1'b0;
      cpu_addr_q  <= '0;
      cpu_wdata_q <= '0;
      vdg_v_q     <= 1'b0;
      vdg_addr_q  <= '0;
      cpu_wait_q  <= '0;
      cpu_overrun <= 1'b0;
      vdg_overrun <= 1'b0;
      ram_en      <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      cmp_v_q     <= 1'b0;
      cmp_cpu_q   <= 1'b0;
      cmp_we_q    <= 1'b0;
      cpu_ack     <= 1'b0;
      vdg_valid   <= 1'b0;
      cpu_rdata   <= '0;
      vdg_rdata   <= '0;
    end else begin
      if (gnt_vdg) begin
        state_q  <= StVdgAcc;
        ram_en   <= 1'b1;
        ram_we   <= 1'b0;
        ram_addr <= vdg_addr_q;
      end else if (gnt_cpu) begin
        state_q  <= StCpuAcc;
        ram_en   <= 1'b1;
        ram_we   <= cpu_we_q;
        ram_addr <= cpu_addr_q;
        if (cpu_we_q) ram_wdata <= cpu_wdata_q;
      end else begin
        state_q <= StIdle;
        ram_en  <= 1'b0;
        ram_we  <= 1'b0;
      end

      // A strobe landing on the slot being granted simply refills it.
      if (cpu_req) begin
        cpu_v_q     <= 1'b1;
        cpu_we_q    <= cpu_we;
        cpu_addr_q  <= cpu_addr;
        cpu_wdata_q <= cpu_wdata;
        if (cpu_v_q && !gnt_cpu) cpu_overrun <= 1'b1;
      end else if (gnt_cpu) begin
        cpu_v_q <= 1'b0;
      end

      if (vdg_req) begin
        vdg_v_q    <= 1'b1;
        vdg_addr_q <= vdg_addr;
        if (vdg_v_q && !gnt_vdg) vdg_overrun <= 1'b1;
      end else if (gnt_vdg) begin
        vdg_v_q <= 1'b0;
      end

      if (gnt_cpu) cpu_wait_q <= '0;
      else if (cpu_v_q && cpu_wait_q != 2'd3) cpu_wait_q <= cpu_wait_q + 2'd1;

      // Stage 1 is the ram_en cycle (state_q); stage 2 waits for ram_rdata.
      cmp_v_q   <= (state_q != StIdle);
      cmp_cpu_q <= (state_q == StCpuAcc);
      cmp_we_q  <= ram_we;
      cpu_ack   <= cmp_v_q && cmp_cpu_q;
      vdg_valid <= cmp_v_q && !cmp_cpu_q;
      if (cmp_v_q && cmp_cpu_q && !cmp_we_q) cpu_rdata <= ram_rdata;
      if (cmp_v_q && !cmp_cpu_q) vdg_rdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_vid_ram_arb.sv
// Scoreboard bench for vid_ram_arb: stimulus queues expected RAM grants and completions,
// a negedge monitor pops and compares them (including the cycle they occur in).
module tb_vid_ram_arb;

  logic        clk25 = 1'b0;
  logic        hard_reset_n;
  logic        cpu_req, cpu_we, vdg_req;
  logic [12:0] cpu_addr, vdg_addr;
  logic [7:0]  cpu_wdata, cpu_rdata, vdg_rdata;
  logic        cpu_ack, vdg_valid;
  logic        ram_en, ram_we;
  logic [12:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata;
  logic        cpu_overrun, vdg_overrun;

  vid_ram_arb #(.ADDR_W(13), .CPU_MAX_WAIT(2)) dut (
    .clk25(clk25), .hard_reset_n(hard_reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .vdg_req(vdg_req), .vdg_addr(vdg_addr), .vdg_rdata(vdg_rdata), .vdg_valid(vdg_valid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .cpu_overrun(cpu_overrun), .vdg_overrun(vdg_overrun)
  );

  always #5 clk25 = ~clk25;

  int cyc = 0;
  always @(posedge clk25) cyc <= cyc + 1;

  // Synchronous single-port RAM model.
  logic [7:0] mem [0:8191];
  always @(posedge clk25) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  typedef struct {
    int          at;
    logic [12:0] addr;
    logic        we;
    logic [7:0]  data;
  } ev_t;

  ev_t ram_q[$];
  ev_t cpu_q[$];
  ev_t vdg_q[$];

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push_ram(input int at, input logic [12:0] a, input logic w, input logic [7:0] d);
    ev_t e;
    e.at = at; e.addr = a; e.we = w; e.data = d;
    ram_q.push_back(e);
  endtask

  task automatic push_cpu(input int at, input logic [7:0] d);
    ev_t e;
    e.at = at; e.addr = '0; e.we = 1'b0; e.data = d;
    cpu_q.push_back(e);
  endtask

  task automatic push_vdg(input int at, input logic [7:0] d);
    ev_t e;
    e.at = at; e.addr = '0; e.we = 1'b0; e.data = d;
    vdg_q.push_back(e);
  endtask

  // Monitor: every output event must match the head of its queue.
  always @(negedge clk25) begin
    ev_t e;
    if (ram_en) begin
      if (ram_q.size() == 0) chk("ram_en_unexpected", 32'(ram_addr), 32'hFFFF_FFFF);
      else begin
        e = ram_q.pop_front();
        chk("ram_en_cycle", 32'(cyc), 32'(e.at));
        chk("ram_addr", 32'(ram_addr), 32'(e.addr));
        chk("ram_we", 32'(ram_we), 32'(e.we));
        if (e.we) chk("ram_wdata", 32'(ram_wdata), 32'(e.data));
      end
    end
    if (cpu_ack) begin
      if (cpu_q.size() == 0) chk("cpu_ack_unexpected", 32'(cpu_rdata), 32'hFFFF_FFFF);
      else begin
        e = cpu_q.pop_front();
        chk("cpu_ack_cycle", 32'(cyc), 32'(e.at));
        chk("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
      end
    end
    if (vdg_valid) begin
      if (vdg_q.size() == 0) chk("vdg_valid_unexpected", 32'(vdg_rdata), 32'hFFFF_FFFF);
      else begin
        e = vdg_q.pop_front();
        chk("vdg_valid_cycle", 32'(cyc), 32'(e.at));
        chk("vdg_rdata", 32'(vdg_rdata), 32'(e.data));
      end
    end
  end

  // One clock of stimulus; the strobes are sampled at the next rising edge.
  task automatic drive(input logic c_r, input logic c_w, input logic [12:0] c_a,
                       input logic [7:0] c_d, input logic v_r, input logic [12:0] v_a);
    cpu_req = c_r; cpu_we = c_w; cpu_addr = c_a; cpu_wdata = c_d;
    vdg_req = v_r; vdg_addr = v_a;
    @(posedge clk25);
    #1;
    cpu_req = 1'b0; vdg_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk25);
    #1;
  endtask

  int t;

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'(i) ^ 8'h3C;
    mem[13'h0123] = 8'hA5;
    mem[13'h0000] = 8'h77;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    vdg_req = 0; vdg_addr = '0;
    hard_reset_n = 1'b0;
    idle(3);
    chk("reset_outputs", {ram_en, ram_we, cpu_ack, vdg_valid, cpu_overrun, vdg_overrun,
        cpu_rdata, vdg_rdata}, 32'h0);
    chk("reset_ram_bus", {ram_addr, ram_wdata}, 32'h0);
    hard_reset_n = 1'b1;

    // Uncontended CPU read of 0x0123.
    t = cyc + 1;
    push_ram(t + 1, 13'h0123, 1'b0, 8'h00);
    push_cpu(t + 3, 8'hA5);
    drive(1, 0, 13'h0123, 8'h00, 0, 13'h0);
    idle(6);

    // Simultaneous CPU write and VDG read: VDG first.
    t = cyc + 1;
    push_ram(t + 1, 13'h0000, 1'b0, 8'h00);
    push_ram(t + 2, 13'h1FFF, 1'b1, 8'h5A);
    push_vdg(t + 3, 8'h77);
    push_cpu(t + 4, 8'hA5);
    drive(1, 1, 13'h1FFF, 8'h5A, 1, 13'h0000);
    idle(6);
    chk("overruns_after_contention", {cpu_overrun, vdg_overrun}, 32'h0);

    // Read back the written byte.
    t = cyc + 1;
    push_ram(t + 1, 13'h1FFF, 1'b0, 8'h00);
    push_cpu(t + 3, 8'h5A);
    drive(1, 0, 13'h1FFF, 8'h00, 0, 13'h0);
    idle(6);

    // VDG every cycle, CPU pending: CPU wins on its third pending cycle.
    t = cyc + 1;
    push_ram(t + 1, 13'h0010, 1'b0, 8'h00);
    push_ram(t + 2, 13'h0011, 1'b0, 8'h00);
    push_ram(t + 3, 13'h0200, 1'b0, 8'h00);
    push_ram(t + 4, 13'h0013, 1'b0, 8'h00);
    push_vdg(t + 3, 8'h2C);
    push_vdg(t + 4, 8'h2D);
    push_cpu(t + 5, 8'h3C);
    push_vdg(t + 6, 8'h2F);
    drive(1, 0, 13'h0200, 8'h00, 1, 13'h0010);
    drive(0, 0, 13'h0000, 8'h00, 1, 13'h0011);
    drive(0, 0, 13'h0000, 8'h00, 1, 13'h0012);
    drive(0, 0, 13'h0000, 8'h00, 1, 13'h0013);
    idle(8);
    chk("vdg_overrun_set", 32'(vdg_overrun), 32'h1);
    chk("cpu_overrun_clear", 32'(cpu_overrun), 32'h0);

    // Two CPU strobes while VDG blocks: latest wins, one ack.
    t = cyc + 1;
    push_ram(t + 1, 13'h0020, 1'b0, 8'h00);
    push_ram(t + 2, 13'h0021, 1'b0, 8'h00);
    push_ram(t + 3, 13'h0301, 1'b0, 8'h00);
    push_vdg(t + 3, 8'h1C);
    push_vdg(t + 4, 8'h1D);
    push_cpu(t + 5, 8'h3D);
    drive(1, 0, 13'h0300, 8'h00, 1, 13'h0020);
    drive(1, 0, 13'h0301, 8'h00, 1, 13'h0021);
    idle(8);
    chk("cpu_overrun_set", 32'(cpu_overrun), 32'h1);

    // Reset in the cycle after ram_en: the completion must vanish.
    t = cyc + 1;
    push_ram(t + 1, 13'h0400, 1'b0, 8'h00);
    drive(1, 0, 13'h0400, 8'h00, 0, 13'h0);
    idle(1);
    idle(1);
    hard_reset_n = 1'b0;
    #1;
    chk("midreset_outputs", {ram_en, ram_we, cpu_ack, vdg_valid, cpu_overrun, vdg_overrun,
        cpu_rdata, vdg_rdata}, 32'h0);
    chk("midreset_ram_bus", {ram_addr, ram_wdata}, 32'h0);
    idle(3);
    hard_reset_n = 1'b1;
    t = cyc + 1;
    push_ram(t + 1, 13'h0055, 1'b0, 8'h00);
    push_cpu(t + 3, 8'h69);
    drive(1, 0, 13'h0055, 8'h00, 0, 13'h0);
    idle(6);

    // Long idle: no ram_en, bus holds its last values.
    idle(100);
    chk("idle_ram_addr", 32'(ram_addr), 32'h0055);
    chk("idle_ram_wdata", 32'(ram_wdata), 32'h0);

    chk("ram_q_drained", 32'(ram_q.size()), 32'h0);
    chk("cpu_q_drained", 32'(cpu_q.size()), 32'h0);
    chk("vdg_q_drained", 32'(vdg_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
